rst_gen: RTL
============

# rst_gen

Reset sequencer sitting directly downstream of the PLL. It consumes the PLL's `clk0_out`, `extlock` and `stdby` and produces the single synchronized system reset for the RV32I core and peripherals. `sys_rst_n` is released only after the lock has been stable for a filter window plus a stretch window. Reset is re-asserted and the sequence restarted whenever lock is lost.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flop depth of every synchronizer; legal range 2–4.
- `LOCK_FILTER`, 4: consecutive `lock_ok` cycles required before stretching; must be ≥ 1.
- `STRETCH_CYCLES`, 16: cycles `sys_rst_n` is held low after the filter passes; must be ≥ 1.
- `CNT_W`, 8: width of the shared filter/stretch counter; must hold max(`LOCK_FILTER`, `STRETCH_CYCLES`).

Ports:
- `clk`, input, 1: system clock, driven by PLL `clk0_out`.
- `rst_n`, input, 1: external reset. Asynchronous, active-low.
- `extlock`, input, 1: PLL lock, asynchronous to `clk`.
- `stdby`, input, 1: PLL standby, asynchronous. High means not locked.
- `sys_rst_n`, output, 1: system reset, active-low. Asserts asynchronously; deasserts synchronously.
- `rst_state`, output, 2: current FSM state, for debug and LEDs.
- `lock_loss_cnt`, output, 4: saturating count of lock losses while in RUN.

## Operation
- `rst_n` passes through `rst_sync`: assertion is asynchronous, deassertion is synchronous after `SYNC_STAGES` edges. The result, `irst_n`, resets every flop in the block.
- `extlock` and `stdby` each pass through a `SYNC_STAGES` synchronizer reset to 0. `lock_ok = extlock_s & ~stdby_s`.
- Reset values: state = WAIT, counter = 0, `sys_rst_n` = 0, `rst_state` = 2'b00, `lock_loss_cnt` = 0.
- State encodings:
  - WAIT = 2'b00
  - STRETCH = 2'b01
  - RUN = 2'b10
  - FAULT = 2'b11
- WAIT:
  - `lock_ok` = 0 clears the counter.
  - Otherwise the counter increments.
  - When `lock_ok` is high and counter == `LOCK_FILTER`-1: go to STRETCH and clear the counter.
- STRETCH:
  - `lock_ok` = 0: go to WAIT and clear the counter.
  - Otherwise the counter increments.
  - When counter == `STRETCH_CYCLES`-1: go to RUN.
- RUN:
  - `sys_rst_n` = 1.
  - `lock_ok` = 0: go to FAULT; `lock_loss_cnt` increments, saturating at 15.
- FAULT:
  - `sys_rst_n` = 0.
  - Go unconditionally to WAIT on the next edge with the counter cleared.
- `sys_rst_n` is a flop whose next value is (next_state == RUN), so it is glitch-free.
- `rst_n` low at any time, including mid-STRETCH or in RUN:
  - `sys_rst_n` and all state go to reset values immediately, without a clock.
  - `lock_loss_cnt` is also cleared.
- Counter width: compares use `CNT_W`; the counter never exceeds the terminal value.

## Timing
- `extlock` = 1 and `stdby` = 0 held throughout: `sys_rst_n` rises exactly `SYNC_STAGES` + `SYNC_STAGES` + `LOCK_FILTER` + `STRETCH_CYCLES` rising edges after the first edge that samples `rst_n` high. With defaults this is 24 edges.
- Lock-loss reaction: `lock_ok` falls `SYNC_STAGES` edges after `extlock` falls. `sys_rst_n` falls on the following edge, so `extlock` low → `sys_rst_n` low takes `SYNC_STAGES`+1 edges.
- After a loss, re-release takes at least 1 (FAULT) + `LOCK_FILTER` + `STRETCH_CYCLES` edges once `lock_ok` is high again.
- A `lock_ok` glitch shorter than `LOCK_FILTER` cycles in WAIT restarts the filter. It never releases reset early.

## Configuration
- `RST_GEN_LOCK_BYPASS_EN`:
  - Defined: `lock_ok` is forced to 1. `extlock` and `stdby` are ignored, and their synchronizers are not instantiated. Release happens `SYNC_STAGES` + `LOCK_FILTER` + `STRETCH_CYCLES` edges after `rst_n` sync release (22 with defaults). FAULT is unreachable and `lock_loss_cnt` stays 0. This mode is for simulation builds whose PLL model never asserts lock.
  - Undefined: full lock-qualified behaviour as described above.

## Structure
- Package `rst_gen_pkg` holds:
  - the state encodings (WAIT, STRETCH, RUN, FAULT);
  - default constants for `SYNC_STAGES`, `LOCK_FILTER` and `STRETCH_CYCLES`.
- Sub-module `rst_sync` is a parameterized `SYNC_STAGES` flop chain with async active-low clear and data input.
  - Used for the reset path (data input tied to 1).
  - Used for `extlock` and `stdby` (data input = signal).

## Test plan
- Cold start, defaults: `rst_n` low 5 cycles then high, `extlock`=1, `stdby`=0 → `sys_rst_n` rises on edge 24. `rst_state` sequence is 00, then 01, then 10.
- Filter glitch: `extlock` drops for 2 cycles during WAIT → counter restarts. Release is delayed by the glitch length plus elapsed filter cycles, and `lock_loss_cnt` = 0.
- Loss in STRETCH: `extlock` low at stretch count 8 → return to WAIT, `sys_rst_n` stays 0, `lock_loss_cnt` = 0.
- Loss in RUN, 16 times: each loss → `sys_rst_n` low 3 edges after `extlock` falls. `rst_state` passes through 11; `lock_loss_cnt` counts 1 to 15 and saturates at 15.
- `stdby`=1 with `extlock`=1 → never leaves WAIT. Raising `stdby` in RUN → FAULT, same as a loss.
- Async reset mid-RUN: `rst_n` low between clock edges → `sys_rst_n` and `lock_loss_cnt` are 0 before the next edge. With `RST_GEN_LOCK_BYPASS_EN` defined and `extlock`=0, release occurs on edge 22.

Source files
------------

// File: rtl/rst_gen_pkg.sv
// ============================================================================
// Module      : rst_gen_pkg
// Description : Shared definitions for the PLL-qualified reset sequencer:
//               FSM state encodings, default timing constants and the
//               saturating lock-loss counter helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rst_gen_pkg;

  // Default build-time timing constants
  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned LOCK_FILTER_DEF    = 4;
  localparam int unsigned STRETCH_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF          = 8;

  // FSM state encodings (also exported on rst_state for LEDs/debug)
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_WAIT    = 2'b00;
  localparam logic [ST_W-1:0] ST_STRETCH = 2'b01;
  localparam logic [ST_W-1:0] ST_RUN     = 2'b10;
  localparam logic [ST_W-1:0] ST_FAULT   = 2'b11;

  // Lock-loss counter
  localparam int unsigned   LOSS_W   = 4;
  localparam logic [LOSS_W-1:0] LOSS_MAX = 4'hF;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [LOSS_W-1:0] loss_sat_inc(input logic [LOSS_W-1:0] v);
    return (v == LOSS_MAX) ? v : v + 4'd1;
  endfunction

endpackage : rst_gen_pkg

`default_nettype wire

// File: rtl/rst_gen_if.sv
// ============================================================================
// Module      : rst_gen_if
// Description : Bundle between the PLL / system side and the reset sequencer.
// Signals     : extlock       - PLL lock, asynchronous to clk
//               stdby         - PLL standby, asynchronous, high = not locked
//               sys_rst_n     - synchronized system reset, active-low
//               rst_state     - sequencer state for debug/LEDs
//               lock_loss_cnt - saturating count of lock losses in RUN
// Modports    : master - environment side (drives PLL status, sees reset)
//               slave  - rst_gen side
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface rst_gen_if;
  import rst_gen_pkg::*;

  logic              extlock;
  logic              stdby;
  logic              sys_rst_n;
  logic [ST_W-1:0]   rst_state;
  logic [LOSS_W-1:0] lock_loss_cnt;

  modport master (
    output extlock,
    output stdby,
    input  sys_rst_n,
    input  rst_state,
    input  lock_loss_cnt
  );

  modport slave (
    input  extlock,
    input  stdby,
    output sys_rst_n,
    output rst_state,
    output lock_loss_cnt
  );

endinterface : rst_gen_if

`default_nettype wire

// File: rtl/rst_sync.sv
// ============================================================================
// Module      : rst_sync
// Description : STAGES-deep flop chain with asynchronous active-low clear.
//               With d_i tied high it is a reset synchronizer (async assert,
//               sync deassert); with d_i = a signal it is a plain level
//               synchronizer that reads 0 while cleared.
// Parameters  : STAGES - chain depth, 2..4
// Ports       : clk   - destination clock
//               rst_n - asynchronous clear, active-low
//               d_i   - data input (asynchronous to clk)
//               q_o   - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : rst_sync

`default_nettype wire

// File: rtl/rst_gen.sv
// ============================================================================
// Module      : rst_gen
// Description : Reset sequencer downstream of the PLL. Releases the system
//               reset only after PLL lock has been stable for LOCK_FILTER
//               cycles followed by STRETCH_CYCLES cycles; re-asserts it and
//               restarts the sequence whenever lock is lost.
// Parameters  : SYNC_STAGES    - depth of every synchronizer (2..4)
//               LOCK_FILTER    - consecutive lock_ok cycles before stretch
//               STRETCH_CYCLES - cycles held in reset after the filter
//               CNT_W          - width of the shared filter/stretch counter
// Ports       : clk   - system clock (PLL clk0_out)
//               rst_n - external reset, asynchronous, active-low
//               bus   - rst_gen_if.slave: extlock, stdby in;
//                       sys_rst_n, rst_state, lock_loss_cnt out
// Config      : RST_GEN_LOCK_BYPASS_EN - when defined, lock_ok is forced high
//               and the extlock/stdby synchronizers are not built.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rst_gen
  import rst_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned LOCK_FILTER    = LOCK_FILTER_DEF,
  parameter int unsigned STRETCH_CYCLES = STRETCH_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  rst_gen_if.slave bus
);

  // Terminal counter values, sized to the counter for the compares
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STR_LAST  = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Internal reset: asserts with rst_n, releases SYNC_STAGES edges later.
  // Every flop below, including the lock synchronizers, is cleared by it.
  // --------------------------------------------------------------------------
  logic irst_n;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (1'b1),
    .q_o   (irst_n)
  );

  // --------------------------------------------------------------------------
  // Lock qualification
  // --------------------------------------------------------------------------
  logic lock_ok;

`ifdef RST_GEN_LOCK_BYPASS_EN
  // PLL model never locks in these builds: treat the clock as always good.
  assign lock_ok = 1'b1;
`else
  logic extlock_s;
  logic stdby_s;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_extlock_sync (
    .clk   (clk),
    .rst_n (irst_n),
    .d_i   (bus.extlock),
    .q_o   (extlock_s)
  );

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_stdby_sync (
    .clk   (clk),
    .rst_n (irst_n),
    .d_i   (bus.stdby),
    .q_o   (stdby_s)
  );

  // Both synchronizers clear to 0, so lock_ok reads low until the first
  // synchronized extlock arrives.
  assign lock_ok = extlock_s & ~stdby_s;
`endif

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [LOSS_W-1:0] loss_q;
  logic [LOSS_W-1:0] loss_d;
  logic              sys_rst_n_q;
  logic              sys_rst_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;

    case (state_q)
      ST_WAIT: begin
        // Any lock_ok dropout restarts the filter from zero.
        if (!lock_ok) begin
          cnt_d = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STRETCH: begin
        if (!lock_ok) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STR_LAST) begin
          // Counter is parked at zero in RUN so it never passes terminal.
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        if (!lock_ok) begin
          state_d = ST_FAULT;
          loss_d  = loss_sat_inc(loss_q);
        end
      end

      ST_FAULT: begin
        // One-cycle marker state so the loss is visible on rst_state.
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered from next-state so the released reset cannot glitch.
  assign sys_rst_n_d = (state_d == ST_RUN);

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      loss_q      <= '0;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign bus.sys_rst_n     = sys_rst_n_q;
  assign bus.rst_state     = state_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule : rst_gen

`default_nettype wire
